// File: rtl/bus_pkg.sv
// Shared bus definitions for the dual-port instruction/data memory.
package bus_pkg;

    localparam int XLEN = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } ttype_t;

    typedef enum logic [1:0] {
        BYTE = 2'd0,
        HALF = 2'd1,
        WORD = 2'd2
    } tsize_t;

endpackage

// File: rtl/fetch_prefetch_pkg.sv
// Fetch-stage local types: FSM states and the width of one buffered {pc, instruction} pair.
package fetch_prefetch_pkg;

    import bus_pkg::*;

    localparam int ENTRY_W = 2 * XLEN;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_FULL  = 2'd2
    } fetch_state_t;

endpackage

// File: rtl/slave_bus_if.sv
// Simple single-cycle memory port: the slave answers rdata combinationally for addr.
interface slave_bus_if;

    import bus_pkg::*;

    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [XLEN-1:0] rdata;
    ttype_t          ttype;
    tsize_t          tsize;

    modport master (output addr, output wdata, output ttype, output tsize, input rdata);
    modport slave  (input addr, input wdata, input ttype, input tsize, output rdata);

endinterface

// File: rtl/fetch_prefetch_fifo.sv
// Synchronous FIFO with a registered head word; the head reads 0 whenever the FIFO is empty.
module sync_fifo #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         din,
    output logic [WIDTH-1:0]         head,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_next;
    logic [AW:0]      count_next;
    logic [WIDTH-1:0] head_next;

    assign full = (count == (AW+1)'(DEPTH));

    // Work out the post-edge read pointer, occupancy and head word so the head can be registered.
    always_comb begin
        rd_ptr_next = rd_ptr;
        count_next  = count;
        head_next   = '0;
        if (flush) begin
            rd_ptr_next = '0;
            count_next  = '0;
        end else begin
            if (pop) begin
                rd_ptr_next = rd_ptr + 1'b1;
            end
            count_next = count + (AW+1)'(push) - (AW+1)'(pop);
            if (count_next != '0) begin
                head_next = (push && (wr_ptr == rd_ptr_next)) ? din : mem[rd_ptr_next];
            end
        end
    end

    // Storage write; a flush leaves the old words in place since the pointers make them unreachable.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (!flush && push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer, occupancy and registered-head update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            empty  <= 1'b1;
            head   <= '0;
        end else begin
            wr_ptr <= flush ? '0 : wr_ptr + AW'(push);
            rd_ptr <= rd_ptr_next;
            count  <= count_next;
            empty  <= (count_next == '0);
            head   <= head_next;
        end
    end

endmodule

// File: rtl/fetch_prefetch.sv
// Instruction fetch stage: PC, fetch FSM and prefetch buffer feeding decode through valid/ready.
module fetch_prefetch
    import bus_pkg::*;
    import fetch_prefetch_pkg::*;
#(
    parameter int              DEPTH    = 4,
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst_n,
    slave_bus_if.master     ibus,
    input  logic            fetch_en,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [XLEN-1:0] inst_data,
    output logic [XLEN-1:0] inst_pc
);

    localparam int AW = $clog2(DEPTH);

    fetch_state_t     state_q;
    fetch_state_t     state_next;
    logic [XLEN-1:0]  pc_q;
    logic             push;
    logic             pop;
    logic             fifo_full;
    logic             fifo_empty;
    logic [AW:0]      fifo_count;
    logic [ENTRY_W-1:0] fifo_head;

    assign inst_valid = !fifo_empty;
    assign inst_pc    = fifo_head[ENTRY_W-1:XLEN];
    assign inst_data  = fifo_head[XLEN-1:0];

    // A redirect kills whatever decode is looking at, so it suppresses both push and pop.
    assign pop  = inst_valid && inst_ready && !redirect_valid;
    assign push = (state_q == ST_FETCH) && fetch_en && !redirect_valid && (!fifo_full || pop);

    assign ibus.addr  = pc_q;
    assign ibus.wdata = '0;
    assign ibus.tsize = WORD;
    assign ibus.ttype = (state_q == ST_FETCH) ? READ : IDLE;

    sync_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .flush (redirect_valid),
        .push  (push),
        .pop   (pop),
        .din   ({pc_q, ibus.rdata}),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty),
        .count (fifo_count)
    );

    // Next-state logic; a redirect overrides every other transition.
    always_comb begin
        state_next = state_q;
        if (redirect_valid) begin
            state_next = fetch_en ? ST_FETCH : ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (fetch_en) state_next = ST_FETCH;
                end
                ST_FETCH: begin
                    if (!fetch_en) state_next = ST_IDLE;
                    else if ((fifo_count == (AW+1)'(DEPTH)) && !pop) state_next = ST_FULL;
                end
                ST_FULL: begin
                    if (!fetch_en) state_next = ST_IDLE;
                    else if (pop) state_next = ST_FETCH;
                end
                default: state_next = ST_IDLE;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_next;
    end

    // Program counter: redirect target is word-aligned, otherwise advance once per buffered word.
    always_ff @(posedge clk) begin
        if (!rst_n)              pc_q <= RESET_PC;
        else if (redirect_valid) pc_q <= {redirect_pc[XLEN-1:2], 2'b00};
        else if (push)           pc_q <= pc_q + 32'd4;
    end

endmodule

// File: doc/fetch_prefetch.md
# fetch_prefetch

Instruction fetch stage that masters the read-only instruction port of the dual-port instruction/data memory. It holds the program counter, issues one word read per cycle on `ibus`, and buffers `{pc, instruction}` pairs in a small prefetch FIFO. Decode pops from that FIFO with a valid/ready handshake. A redirect from execute (branch, jump or trap) flushes the buffer and restarts fetch at a new address.

## Interface
Parameters:
- `DEPTH`, 4: prefetch FIFO entries; power of two, at least 2.
- `RESET_PC`, 32'h0000_0000: PC loaded on reset; must be word-aligned.

Ports:
- `clk`, input, 1: single clock; all state updates on the rising edge.
- `rst_n`, input, 1: synchronous, active-low reset.
- `ibus`, `slave_bus_if.master`, n/a: instruction port toward the memory's `ibus`.
- `fetch_en`, input, 1: permits new fetches; the FIFO still drains when low.
- `redirect_valid`, input, 1: flush the FIFO and load `redirect_pc`.
- `redirect_pc`, input, 32: new fetch address; bits [1:0] are ignored.
- `inst_valid`, output, 1: the FIFO head is valid.
- `inst_ready`, input, 1: decode accepts the head.
- `inst_data`, output, 32: instruction at the FIFO head.
- `inst_pc`, output, 32: address of `inst_data`.

## Operation
- The memory returns `ibus.rdata` combinationally for `ibus.addr` in the same cycle.
- `ibus.addr` = `pc`; `ibus.tsize` = WORD; `ibus.wdata` = 0.
- `ibus.ttype` is READ in state FETCH and IDLE otherwise.
- States:
  - IDLE: `fetch_en` = 0 or reset. Goes to FETCH when `fetch_en` = 1.
  - FETCH: issuing reads. Goes to FULL when the FIFO is full and there is no pop. Goes to IDLE when `fetch_en` drops.
  - FULL: stalled. Goes to FETCH on a pop. Goes to IDLE when `fetch_en` drops.
- Redirect forces FETCH if `fetch_en` = 1, else IDLE.
- Push is the cycle's fetch result:
  - Condition: state FETCH && !redirect_valid && (count < DEPTH || pop).
  - Write `{pc, ibus.rdata}` at the tail, then `pc <= pc + 4`.
- Pop occurs when `inst_valid && inst_ready && !redirect_valid`.
- Simultaneous push and pop while full is legal; count is unchanged.
- Redirect has the highest priority:
  - count <= 0, read and write pointers <= 0, `pc <= {redirect_pc[31:2], 2'b00}`.
  - Any push or pop in that cycle is discarded; decode treats a redirect as a kill of its current input.
- PC arithmetic is 32-bit modulo; 32'hFFFF_FFFC + 4 wraps to 0 without error.
- FIFO pointers are log2(DEPTH) bits and wrap naturally. The count is log2(DEPTH)+1 bits.

## Timing
- Reset values: `pc` = RESET_PC, count = 0, pointers = 0, state IDLE.
- Outputs in reset: `inst_valid` = 0, `inst_data` = 0, `inst_pc` = 0, `ibus.addr` = RESET_PC, `ibus.ttype` = IDLE.
- FIFO storage resets to 0, so the head reads 0 when empty.
- Reset asserted mid-stream discards all buffered entries at that edge.
- Address-to-valid latency is 1 cycle: a word fetched in cycle N appears at the head in cycle N+1 when the FIFO was empty.
- Redirect latency is 2 cycles:
  - Redirect in cycle N.
  - Fetch of the new PC in cycle N+1.
  - `inst_valid` with `inst_pc` = new PC in cycle N+2.
  - `inst_valid` = 0 in cycle N+1.
- Throughput is one instruction per cycle with `inst_ready` held high.
- `inst_valid`, `inst_data` and `inst_pc` come directly from registers, with no combinational path from `inst_ready`.
- `fetch_en` falling takes effect on the same cycle: no push occurs in that cycle.

## Structure
- Shared `bus_pkg` holds `ttype_t` (IDLE/READ/WRITE), `tsize_t` and an `XLEN`=32 constant.
- One sub-module, `sync_fifo #(WIDTH, DEPTH)`:
  - Push/pop/flush inputs; full/empty/count outputs.
  - Registered head, reset to 0.
- `fetch_prefetch` holds the PC, the FSM and the push/pop/redirect arbitration.

## Test plan
- Reset with RESET_PC = 32'h100, then `fetch_en` = 1 and `inst_ready` = 1 -> `inst_pc` = 0x100, 0x104, 0x108 on consecutive cycles, with `inst_data` equal to the memory contents.
- `inst_ready` = 0 for 10 cycles, DEPTH = 4 -> exactly 4 pushes, state FULL, `ibus.addr` frozen at 0x110. Releasing ready -> 0x100..0x10C then 0x110 with no gap or duplicate.
- Redirect to 32'h203 while the FIFO holds 3 entries and `inst_ready` = 1 -> next-cycle `inst_valid` = 0, then `inst_pc` = 0x200. No stale entry appears.
- Push and pop on the same cycle while full -> count stays 4 and ordering is preserved. Redirect coinciding with push and pop -> count = 0.
- PC = 32'hFFFF_FFF8 streaming -> `inst_pc` = FFFF_FFF8, FFFF_FFFC, 0000_0000.
- `rst_n` low for one cycle mid-stream -> `inst_valid` = 0 next cycle, `ibus.addr` = RESET_PC, no residual entries after release.
